// File: rtl/snake_pkg.sv
// Shared constants and FSM state type for the snake body engine.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam int unsigned X_MAX_DEF = 160;
  localparam int unsigned Y_MAX_DEF = 120;

  localparam logic [2:0] HEAD_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StCheck,
    StDrawHead,
    StEraseTail,
    StDead
  } snake_state_e;

endpackage

// File: rtl/snake_pos_ram.sv
// Segment coordinate store: one write port, one synchronous read port, {x,y} words.
module snake_pos_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 15
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/snake_body.sv
// Snake body engine: head movement, collision scan over the segment ring, plot stream.
// Define WRAP_EN to make the playfield edges wrap instead of killing the snake.
module snake_body import snake_pkg::*; #(
  parameter int unsigned X_MAX   = X_MAX_DEF,
  parameter int unsigned Y_MAX   = Y_MAX_DEF,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned INIT_X  = 80,
  parameter int unsigned INIT_Y  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [3:0]  dirControl,
  input  logic [10:0] grow,
  output logic [7:0]  h_x,
  output logic [6:0]  h_y,
  output logic [10:0] length,
  output logic        dead,
  output logic        plot_valid,
  input  logic        plot_ready,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  plot_colour
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam logic [7:0]  XLAST     = 8'(X_MAX - 1);
  localparam logic [6:0]  YLAST     = 7'(Y_MAX - 1);
  localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
  localparam logic [14:0] INIT_XY   = {8'(INIT_X), 7'(INIT_Y)};

  snake_state_e r_state, w_state_d;
  logic [1:0]    r_dir, w_dir_d;
  logic [7:0]    r_hx, w_hx_d, r_nx, w_nx_d;
  logic [6:0]    r_hy, w_hy_d, r_ny, w_ny_d;
  logic [AW-1:0] r_head_ptr, w_head_ptr_d, r_tail_ptr, w_tail_ptr_d;
  logic [10:0]   r_len, w_len_d, r_cnt, w_cnt_d;
  logic [14:0]   r_tail_xy, w_tail_xy_d;
  logic          r_full_push, w_full_push_d;
  logic          r_plot_valid, w_plot_valid_d;
  logic [7:0]    r_plot_x, w_plot_x_d;
  logic [6:0]    r_plot_y, w_plot_y_d;
  logic [2:0]    r_plot_col, w_plot_col_d;

  logic [10:0]   w_target;
  logic          w_req_onehot;
  logic [1:0]    w_req_dir;
  logic [7:0]    w_mx;
  logic [6:0]    w_my;
  logic          w_wall;
  logic [14:0]   w_rd_data;
  logic [AW-1:0] w_rd_addr, w_push_addr, w_waddr;
  logic          w_hit, w_push, w_we;
  logic [14:0]   w_wdata;

  assign w_target = (grow == 11'd0) ? 11'd1 : ((grow > MAX_LEN_L) ? MAX_LEN_L : grow);
  assign w_req_onehot = (dirControl != 4'd0) && ((dirControl & (dirControl - 4'd1)) == 4'd0);

  always_comb begin
    w_req_dir = DIR_RIGHT;
    if (dirControl[1]) w_req_dir = DIR_LEFT;
    if (dirControl[2]) w_req_dir = DIR_DOWN;
    if (dirControl[3]) w_req_dir = DIR_UP;
  end

  // Candidate head one cell along r_dir; w_wall flags an edge crossing (w_mx/w_my hold the wrap).
  always_comb begin
    w_mx   = r_hx;
    w_my   = r_hy;
    w_wall = 1'b0;
    case (r_dir)
      DIR_RIGHT: if (r_hx == XLAST) begin w_wall = 1'b1; w_mx = 8'd0; end
                 else w_mx = r_hx + 8'd1;
      DIR_LEFT:  if (r_hx == 8'd0) begin w_wall = 1'b1; w_mx = XLAST; end
                 else w_mx = r_hx - 8'd1;
      DIR_DOWN:  if (r_hy == YLAST) begin w_wall = 1'b1; w_my = 7'd0; end
                 else w_my = r_hy + 7'd1;
      DIR_UP:    if (r_hy == 7'd0) begin w_wall = 1'b1; w_my = YLAST; end
                 else w_my = r_hy - 7'd1;
      default: ;
    endcase
  end

  // Scan walks tail->head; data for index cnt-1 arrives while index cnt is addressed.
  assign w_rd_addr   = r_tail_ptr + r_cnt[AW-1:0];
  assign w_push_addr = r_head_ptr + 1'b1;
  assign w_hit       = (r_state == StCheck) && (r_cnt != 11'd0) && (w_rd_data == {r_nx, r_ny});
  assign w_push      = (r_state == StCheck) && (r_cnt == r_len) && !w_hit;

  // Reset seeds slot 0 with the initial head through the normal write port.
  assign w_we    = rst | w_push;
  assign w_waddr = rst ? '0 : w_push_addr;
  assign w_wdata = rst ? INIT_XY : {r_nx, r_ny};

  snake_pos_ram #(
    .Depth (MAX_LEN),
    .Width (15)
  ) u_pos_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_d      = r_state;
    w_dir_d        = r_dir;
    w_hx_d         = r_hx;
    w_hy_d         = r_hy;
    w_nx_d         = r_nx;
    w_ny_d         = r_ny;
    w_head_ptr_d   = r_head_ptr;
    w_tail_ptr_d   = r_tail_ptr;
    w_len_d        = r_len;
    w_cnt_d        = r_cnt;
    w_tail_xy_d    = r_tail_xy;
    w_full_push_d  = r_full_push;
    w_plot_valid_d = r_plot_valid;
    w_plot_x_d     = r_plot_x;
    w_plot_y_d     = r_plot_y;
    w_plot_col_d   = r_plot_col;
    case (r_state)
      StIdle: begin
        if (step) begin
          if (w_req_onehot && (w_req_dir != (r_dir ^ 2'd1))) w_dir_d = w_req_dir;
          w_state_d = StMove;
        end
      end
      StMove: begin
        w_nx_d  = w_mx;
        w_ny_d  = w_my;
        w_cnt_d = 11'd0;
`ifdef WRAP_EN
        w_state_d = StCheck;
`else
        w_state_d = w_wall ? StDead : StCheck;
`endif
      end
      StCheck: begin
        if (w_hit) begin
          w_state_d = StDead;
        end else begin
          if (r_cnt == 11'd1) w_tail_xy_d = w_rd_data;
          if (r_cnt == r_len) begin
            // A full ring overwrites the tail slot; length holds and the erase pops it.
            w_full_push_d  = (r_len == MAX_LEN_L);
            w_len_d        = (r_len == MAX_LEN_L) ? r_len : r_len + 11'd1;
            w_head_ptr_d   = w_push_addr;
            w_hx_d         = r_nx;
            w_hy_d         = r_ny;
            w_plot_valid_d = 1'b1;
            w_plot_x_d     = r_nx;
            w_plot_y_d     = r_ny;
            w_plot_col_d   = HEAD_COLOUR;
            w_state_d      = StDrawHead;
          end else begin
            w_cnt_d = r_cnt + 11'd1;
          end
        end
      end
      StDrawHead: begin
        if (plot_ready) begin
          if ((r_len > w_target) || r_full_push) begin
            w_plot_x_d   = r_tail_xy[14:7];
            w_plot_y_d   = r_tail_xy[6:0];
            w_plot_col_d = BG_COLOUR;
            w_state_d    = StEraseTail;
          end else begin
            w_plot_valid_d = 1'b0;
            w_state_d      = StIdle;
          end
        end
      end
      StEraseTail: begin
        if (plot_ready) begin
          w_tail_ptr_d   = r_tail_ptr + 1'b1;
          w_len_d        = r_full_push ? r_len : r_len - 11'd1;
          w_full_push_d  = 1'b0;
          w_plot_valid_d = 1'b0;
          w_state_d      = StIdle;
        end
      end
      StDead: begin
        w_plot_valid_d = 1'b0;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_dir        <= DIR_RIGHT;
      r_hx         <= 8'(INIT_X);
      r_hy         <= 7'(INIT_Y);
      r_nx         <= 8'(INIT_X);
      r_ny         <= 7'(INIT_Y);
      r_head_ptr   <= '0;
      r_tail_ptr   <= '0;
      r_len        <= 11'd1;
      r_cnt        <= 11'd0;
      r_tail_xy    <= INIT_XY;
      r_full_push  <= 1'b0;
      r_plot_valid <= 1'b0;
      r_plot_x     <= 8'd0;
      r_plot_y     <= 7'd0;
      r_plot_col   <= 3'd0;
    end else begin
      r_state      <= w_state_d;
      r_dir        <= w_dir_d;
      r_hx         <= w_hx_d;
      r_hy         <= w_hy_d;
      r_nx         <= w_nx_d;
      r_ny         <= w_ny_d;
      r_head_ptr   <= w_head_ptr_d;
      r_tail_ptr   <= w_tail_ptr_d;
      r_len        <= w_len_d;
      r_cnt        <= w_cnt_d;
      r_tail_xy    <= w_tail_xy_d;
      r_full_push  <= w_full_push_d;
      r_plot_valid <= w_plot_valid_d;
      r_plot_x     <= w_plot_x_d;
      r_plot_y     <= w_plot_y_d;
      r_plot_col   <= w_plot_col_d;
    end
  end

  assign h_x         = r_hx;
  assign h_y         = r_hy;
  assign length      = r_len;
  assign dead        = (r_state == StDead);
  assign plot_valid  = r_plot_valid;
  assign plot_x      = r_plot_x;
  assign plot_y      = r_plot_y;
  assign plot_colour = r_plot_col;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body; compile with WRAP_EN to exercise the wrapping playfield.
module tb_snake_body;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic [3:0]  dirControl = 4'd0;
  logic [10:0] grow = 11'd1;
  logic [7:0]  h_x;
  logic [6:0]  h_y;
  logic [10:0] length;
  logic        dead;
  logic        plot_valid;
  logic        plot_ready = 1'b1;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [17:0] plots [$];

  always #5 clk = ~clk;

  snake_body u_dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .dirControl  (dirControl),
    .grow        (grow),
    .h_x         (h_x),
    .h_y         (h_y),
    .length      (length),
    .dead        (dead),
    .plot_valid  (plot_valid),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour)
  );

  // Record every accepted plot, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && plot_valid && plot_ready) plots.push_back({plot_x, plot_y, plot_colour});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] plot_at(input int i);
    return (plots.size() > i) ? plots[i] : 18'h3ffff;
  endfunction

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    plots.delete();
  endtask

  task automatic do_step(input logic [3:0] d, input int wait_cyc);
    drive_edge();
    step = 1'b1;
    dirControl = d;
    drive_edge();
    step = 1'b0;
    dirControl = 4'd0;
    repeat (wait_cyc) @(posedge clk);
    @(negedge clk);
  endtask

  logic [17:0] held;
  bit          seen;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_hx", 32'(h_x), 32'd80);
    check_eq("rst_hy", 32'(h_y), 32'd60);
    check_eq("rst_len", 32'(length), 32'd1);
    check_eq("rst_dead", 32'(dead), 32'd0);
    check_eq("rst_valid", 32'(plot_valid), 32'd0);
    check_eq("rst_plotx", 32'(plot_x), 32'd0);

    // Single step right at length target 1: draw new head then erase old
    grow = 11'd1;
    do_step(4'b0001, 16);
    check_eq("s1_nplots", 32'(plots.size()), 32'd2);
    check_eq("s1_head_plot", 32'(plot_at(0)), 32'({8'd81, 7'd60, 3'b010}));
    check_eq("s1_erase_plot", 32'(plot_at(1)), 32'({8'd80, 7'd60, 3'b000}));
    check_eq("s1_hx", 32'(h_x), 32'd81);
    check_eq("s1_len", 32'(length), 32'd1);

    // Grow to 3: erase only on the third step
    do_reset();
    grow = 11'd3;
    do_step(4'b0001, 16);
    check_eq("g1_nplots", 32'(plots.size()), 32'd1);
    check_eq("g1_len", 32'(length), 32'd2);
    plots.delete();
    do_step(4'b0001, 16);
    check_eq("g2_nplots", 32'(plots.size()), 32'd1);
    check_eq("g2_len", 32'(length), 32'd3);
    plots.delete();
    do_step(4'b0001, 16);
    check_eq("g3_nplots", 32'(plots.size()), 32'd2);
    check_eq("g3_head_plot", 32'(plot_at(0)), 32'({8'd83, 7'd60, 3'b010}));
    check_eq("g3_erase_plot", 32'(plot_at(1)), 32'({8'd80, 7'd60, 3'b000}));
    check_eq("g3_len", 32'(length), 32'd3);

    // Reverse and multi-hot requests are ignored; a legal turn is taken
    do_step(4'b0010, 16);
    check_eq("rev_hx", 32'(h_x), 32'd84);
    check_eq("rev_hy", 32'(h_y), 32'd60);
    do_step(4'b0011, 16);
    check_eq("multi_hx", 32'(h_x), 32'd85);
    do_step(4'b0100, 16);
    check_eq("turn_hx", 32'(h_x), 32'd85);
    check_eq("turn_hy", 32'(h_y), 32'd61);
    check_eq("turn_len", 32'(length), 32'd3);

    // Walk to the right wall
    do_reset();
    grow = 11'd1;
    for (int i = 0; i < 79; i++) do_step(4'b0001, 10);
    check_eq("wall_pre_hx", 32'(h_x), 32'd159);
    check_eq("wall_pre_dead", 32'(dead), 32'd0);
    plots.delete();
    do_step(4'b0001, 16);
`ifdef WRAP_EN
    check_eq("wrap_dead", 32'(dead), 32'd0);
    check_eq("wrap_hx", 32'(h_x), 32'd0);
    check_eq("wrap_plot", 32'(plot_at(0)), 32'({8'd0, 7'd60, 3'b010}));
`else
    check_eq("wall_dead", 32'(dead), 32'd1);
    check_eq("wall_nplots", 32'(plots.size()), 32'd0);
    check_eq("wall_hx", 32'(h_x), 32'd159);
    check_eq("wall_len", 32'(length), 32'd1);
    do_step(4'b0001, 16);
    check_eq("dead_frozen_hx", 32'(h_x), 32'd159);
    check_eq("dead_valid", 32'(plot_valid), 32'd0);
`endif

    // Self collision at length 5, with a stalled handshake on the down move
    do_reset();
    grow = 11'd5;
    for (int i = 0; i < 4; i++) do_step(4'b0001, 16);
    check_eq("sc_len5", 32'(length), 32'd5);
    plots.delete();
    drive_edge();
    plot_ready = 1'b0;
    do_step(4'b0100, 0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (plot_valid) seen = 1'b1;
    end
    check_eq("stall_seen", 32'(seen), 32'd1);
    held = {plot_x, plot_y, plot_colour};
    check_eq("stall_val", 32'(held), 32'({8'd84, 7'd61, 3'b010}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid_hold", 32'(plot_valid), 32'd1);
      check_eq("stall_data_hold", 32'({plot_x, plot_y, plot_colour}), 32'(held));
    end
    drive_edge();
    plot_ready = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check_eq("stall_nplots", 32'(plots.size()), 32'd2);
    check_eq("stall_head", 32'(plot_at(0)), 32'({8'd84, 7'd61, 3'b010}));
    check_eq("stall_erase", 32'(plot_at(1)), 32'({8'd80, 7'd60, 3'b000}));
    do_step(4'b0010, 16);
    check_eq("sc_left_dead", 32'(dead), 32'd0);
    check_eq("sc_left_hx", 32'(h_x), 32'd83);
    plots.delete();
    do_step(4'b1000, 16);
    check_eq("sc_up_dead", 32'(dead), 32'd1);
    check_eq("sc_up_nplots", 32'(plots.size()), 32'd0);
    do_step(4'b0001, 16);
    check_eq("sc_dead_sticky", 32'(dead), 32'd1);
    check_eq("sc_frozen_hx", 32'(h_x), 32'd83);
    check_eq("sc_frozen_hy", 32'(h_y), 32'd61);
    check_eq("sc_frozen_len", 32'(length), 32'd5);

    // Reset recovers from DEAD
    do_reset();
    @(negedge clk);
    check_eq("rec_dead", 32'(dead), 32'd0);
    check_eq("rec_hx", 32'(h_x), 32'd80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
